mem_responder: RTL and testbench

Memory-side responder for the pipelined core's MEM stage. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It returns read data or write completion with a one-cycle response pulse, and raises `stall` to the hazard unit while a request is outstanding. It is the target end of the data-memory interface the pipeline initiates.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 30 +++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory responder.
//   - state_t       : responder FSM encoding
//   - CNT_W         : width of the wait-state counter
//   - MISALIGN_MASK : byte-offset bits that must be zero for a word access
//   - is_misaligned : helper that flags a non-word-aligned byte address
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAITS = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    localparam int CNT_W = 3;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return ((byte_off & MISALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word array, synchronous write, combinational read.
// Contents are deliberately not reset.
// Ports:
//   clk   in  : clock, rising edge
//   we    in  : write enable
//   addr  in  : word index (shared by read and write)
//   wdata in  : write data
//   rdata out : combinational read data at addr
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [0:(1 << ADDR_W)-1];

    // Synchronous word write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: target end of the pipeline's data-memory interface.
// Accepts one load/store at a time, inserts WAIT wait states, then issues a
// one-cycle rsp_valid pulse with read data or store completion.
// Ports:
//   clk, reset           : clock (rising edge), async active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_we               : 1 = store, 0 = load
//   req_addr, req_wdata  : byte address and store data
//   rsp_valid            : one-cycle completion pulse
//   rsp_err              : misaligned access, qualified by rsp_valid
//   rsp_rdata            : load result (0 for stores/errors), held until next response
//   stall                : hold request to the hazard unit
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        stall
);

    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : {CNT_W{1'b0}};

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               we_r;
    logic [ADDR_W+1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic               rsp_valid_r;
    logic               rsp_err_r;
    logic [31:0]        rsp_rdata_r;

    logic               accept_s;
    logic               enter_resp_s;
    logic               sel_we_s;
    logic [ADDR_W+1:0]  sel_addr_s;
    logic [31:0]        sel_wdata_s;
    logic               misaligned_s;
    logic               mem_we_s;
    logic [31:0]        mem_rdata_s;
    logic               unused_addr_s;

    // Upper address bits alias onto the array by design.
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    assign accept_s  = req_valid && (state_r == ST_IDLE);
    assign req_ready = (state_r == ST_IDLE);
    assign stall     = req_valid && (state_r != ST_RESP);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

    // Operand select: with WAIT=0 the response is produced on the accept edge,
    // before the latches hold the request, so use the live inputs in IDLE.
    always_comb begin
        sel_we_s    = we_r;
        sel_addr_s  = addr_r;
        sel_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            sel_we_s    = req_we;
            sel_addr_s  = req_addr[ADDR_W+1:0];
            sel_wdata_s = req_wdata;
        end else begin
            sel_we_s    = we_r;
            sel_addr_s  = addr_r;
            sel_wdata_s = wdata_r;
        end
    end

    // Decode the edge that moves the FSM into RESP.
    always_comb begin
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE:  enter_resp_s = accept_s && (WAIT == 0);
            ST_WAITS: enter_resp_s = (cnt_r == {CNT_W{1'b0}});
            default:  enter_resp_s = 1'b0;
        endcase
    end

    assign misaligned_s = is_misaligned(sel_addr_s[1:0]);
    // Reset gating keeps a WAIT=0 store from landing while reset is held.
    assign mem_we_s     = enter_resp_s && sel_we_s && !misaligned_s && !reset;

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (sel_addr_s[ADDR_W+1:2]),
        .wdata (sel_wdata_s),
        .rdata (mem_rdata_s)
    );

    // FSM, wait counter, request latches and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            we_r        <= 1'b0;
            addr_r      <= {(ADDR_W+2){1'b0}};
            wdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= enter_resp_s;
            if (enter_resp_s) begin
                rsp_err_r   <= misaligned_s;
                rsp_rdata_r <= (misaligned_s || sel_we_s) ? 32'h0000_0000 : mem_rdata_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r    <= req_we;
                        addr_r  <= req_addr[ADDR_W+1:0];
                        wdata_r <= req_wdata;
                        cnt_r   <= CNT_LOAD;
                        state_r <= (WAIT == 0) ? ST_RESP : ST_WAITS;
                    end
                end
                ST_WAITS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (WAIT=2 and WAIT=0) driven from a
// table of directed accesses, plus a hand-written mid-transaction reset case.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;

    logic        v2, we2, rdy2, rv2, err2, st2;
    logic [31:0] a2, wd2, rd2;
    logic        v0, we0, rdy0, rv0, err0, st0;
    logic [31:0] a0, wd0, rd0;

    logic        sel0;
    logic        o_rdy, o_rv, o_err, o_st;
    logic [31:0] o_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_we(we2), .req_addr(a2),
        .req_wdata(wd2), .req_ready(rdy2), .rsp_valid(rv2), .rsp_err(err2),
        .rsp_rdata(rd2), .stall(st2)
    );

    mem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_ready(rdy0), .rsp_valid(rv0), .rsp_err(err0),
        .rsp_rdata(rd0), .stall(st0)
    );

    // Route the selected DUT's outputs to the checker.
    always_comb begin
        o_rdy = sel0 ? rdy0 : rdy2;
        o_rv  = sel0 ? rv0  : rv2;
        o_err = sel0 ? err0 : err2;
        o_st  = sel0 ? st0  : st2;
        o_rd  = sel0 ? rd0  : rd2;
    end

    typedef struct packed {
        logic        use0;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic use0, input logic val, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (use0) begin
            v0 = val; we0 = we; a0 = addr; wd0 = wdata;
        end else begin
            v2 = val; we2 = we; a2 = addr; wd2 = wdata;
        end
    endtask

    // One full access starting at a negedge with the DUT idle; ends at the
    // negedge after the response cycle (DUT idle again).
    task automatic access(input int idx, input vec_t v);
        int lat;
        bit seen;
        int exp_lat;
        exp_lat = v.use0 ? 1 : 3;
        sel0 = v.use0;
        drive(v.use0, 1'b1, v.we, v.addr, v.wdata);
        #1;
        check("ready_idle", idx, {31'b0, o_rdy}, 32'd1);
        check("stall_req", idx, {31'b0, o_st}, 32'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Requester changes after accept must be ignored.
                drive(v.use0, 1'b1, ~v.we, v.addr ^ 32'h0000_0004, ~v.wdata);
            end
            if (o_rv) begin
                seen = 1'b1;
            end else begin
                check("stall_wait", idx, {31'b0, o_st}, 32'd1);
            end
        end
        check("latency", idx, lat, exp_lat);
        check("rsp_err", idx, {31'b0, o_err}, {31'b0, v.exp_err});
        check("rsp_rdata", idx, o_rd, v.exp_rdata);
        check("stall_resp", idx, {31'b0, o_st}, 32'd0);
        drive(v.use0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("pulse_end", idx, {31'b0, o_rv}, 32'd0);
        check("rdata_hold", idx, o_rd, v.exp_rdata);
        check("ready_again", idx, {31'b0, o_rdy}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'h1234_5678, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,         1'b0, 32'h1234_5678};
        vecs[2]  = '{1'b0, 1'b1, 32'h11,  32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h10,  32'h0,         1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h000, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[6]  = '{1'b0, 1'b0, 32'h12,  32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h20,  32'h0000_0055, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h10,  32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b0, 32'h13,  32'h0,         1'b1, 32'h0};

        sel0 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        check("rst_ready", 0, {31'b0, o_rdy}, 32'd1);
        check("rst_rv", 0, {31'b0, o_rv}, 32'd0);
        check("rst_err", 0, {31'b0, o_err}, 32'd0);
        check("rst_rdata", 0, o_rd, 32'h0);
        check("rst_stall_lo", 0, {31'b0, o_st}, 32'd0);
        v2 = 1'b1;
        #1;
        check("rst_stall_hi", 0, {31'b0, o_st}, 32'd1);
        v2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            access(i, vecs[i]);
        end

        // Reset pulsed during the wait state of a store to 0x20.
        sel0 = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h0000_0001);
        @(negedge clk);
        check("mid_accepted", 0, {31'b0, o_rdy}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 0, {31'b0, o_rdy}, 32'd1);
        check("mid_rst_rv", 0, {31'b0, o_rv}, 32'd0);
        check("mid_rst_err", 0, {31'b0, o_err}, 32'd0);
        check("mid_rst_rdata", 0, o_rd, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_late_rsp", k, {31'b0, o_rv}, 32'd0);
        end
        access(100, '{1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_0055});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
